fetch_queue: RTL and testbench
==============================

FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4: instruction queue entries, power of two, minimum 2.
REQ-002 The block SHALL have parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-003 clk  input  1  the single clock; all state updates on the rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 redirect  input  1  flush the queue and restart fetch at redirect_pc (taken branch or jump).
REQ-006 redirect_pc  input  32  new fetch address; bits [1:0] are ignored and treated as 0.
REQ-007 imem_req  output  1  instruction-memory read strobe.
REQ-008 imem_addr  output  32  read address; equals fetch_pc at all times.
REQ-009 imem_rdata  input  32  read data, valid exactly one cycle after the cycle with imem_req=1.
REQ-010 inst_valid  output  1  queue head holds a valid instruction.
REQ-011 inst_ready  input  1  decode accepts the head this cycle.
REQ-012 inst  output  32  head instruction word.
REQ-013 inst_pc  output  32  address of the head instruction.

Function
REQ-014 fetch_pc SHALL be a 32-bit register that increments by 4 modulo 2^32 in every cycle with imem_req=1 (32'hFFFF_FFFC wraps to 0).
REQ-015 imem_req SHALL be 1 iff reset=0, redirect=0 and (count + inflight) < DEPTH, where count is queue occupancy and inflight is the one-bit outstanding-read flag.
REQ-016 inflight SHALL be set in the cycle after a request, and the issuing address SHALL be captured in pending_pc.
REQ-017 When inflight=1 and no redirect occurs, {imem_rdata, pending_pc} SHALL be pushed at the tail; the entry becomes visible at the head no earlier than the following cycle (no bypass).
REQ-018 Fetch latency SHALL be: request in cycle N -> inst_valid=1 with that instruction in cycle N+2 when the queue was empty.
REQ-019 A pop SHALL occur iff inst_valid=1 and inst_ready=1; a pop and a push in the same cycle leave count unchanged.
REQ-020 inst_valid SHALL equal (count != 0); inst and inst_pc SHALL be 0 whenever inst_valid=0.
REQ-021 Sustained throughput SHALL be one instruction per cycle while inst_ready=1.
REQ-022 When the queue is full, nothing SHALL be lost: the capacity rule of REQ-015 guarantees a slot for every in-flight response.
REQ-023 When inst_ready=0, the head SHALL hold inst and inst_pc stable.
REQ-024 On redirect=1 the following SHALL hold: the next cycle has count=0; a response arriving in the redirect cycle or the next cycle is discarded; fetch_pc becomes {redirect_pc[31:2],2'b00}; imem_req is 0 in the redirect cycle.
REQ-025 The first request after a redirect SHALL be issued in the cycle after the redirect, with imem_addr equal to the redirect target.
REQ-026 A handshake completing in the redirect cycle SHALL count as consumed; the remaining entries are flushed.
REQ-027 Back-to-back redirects SHALL each take effect, the last one winning; the queue and inflight stay empty throughout.

Reset
REQ-028 While reset=1, the block SHALL drive imem_req=0, imem_addr=RESET_PC, inst_valid=0, inst=0 and inst_pc=0.
REQ-029 Reset SHALL clear count, the head and tail pointers, and inflight.
REQ-030 Reset SHALL have priority over redirect, and over any response arriving in the reset cycle.
REQ-031 Reset asserted mid-operation SHALL discard all queued and in-flight instructions; the first request with imem_addr=RESET_PC occurs in the first cycle with reset=0.

Structure
REQ-032 Shared package riscv_pkg SHALL hold XLEN=32, ILEN=32, the RESET_PC default and INST_NOP=32'h0000_0013; this block SHALL import them.
REQ-033 Queue storage and pointers SHALL be one sub-module sync_fifo (parameters WIDTH and DEPTH; ports push, pop, flush, full, empty, count), instantiated with WIDTH=64.
REQ-034 The fetch_pc, inflight and pending_pc registers SHALL live in fetch_queue itself.

Verification
REQ-035 Reset then release, inst_ready=1, memory returning addr+32'h100 -> requests at 0,4,8,...; first inst_valid 2 cycles after release with inst=32'h100, inst_pc=0; then one per cycle.
REQ-036 inst_ready=0 from release, DEPTH=4 -> exactly 4 requests (0,4,8,C), imem_req then stays 0; head inst_pc=0 held stable; raising inst_ready resumes requests at 32'h10 with no lost or duplicated PC.
REQ-037 Redirect to 32'h0000_2002 while 3 entries are queued and a read is in flight -> next cycle inst_valid=0; imem_addr=32'h2000; the stale response is never presented; next inst_pc=32'h2000.
REQ-038 RESET_PC=32'hFFFF_FFF8, inst_ready=1 -> inst_pc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000, 0000_0004.
REQ-039 Reset asserted for 1 cycle with the queue full and a read in flight -> all outputs at reset values in that cycle; the following sequence is identical to REQ-035.
REQ-040 Random inst_ready plus random redirects against a reference PC model -> the inst_pc stream is strictly sequential between redirects, with no drop or duplicate, and count never exceeds DEPTH.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RISC-V machine parameters and the fetch-queue entry layout.
package riscv_pkg;

  localparam int XLEN = 32;
  localparam int ILEN = 32;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [ILEN-1:0] INST_NOP = 32'h0000_0013;

  typedef struct packed {
    logic [ILEN-1:0] inst;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

  // Instruction addresses are word aligned; the low two bits carry no meaning.
  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
    return {pc[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_queue_if.sv
// Redirect, instruction-memory and decode-side signals of the fetch queue.
interface fetch_queue_if;
  import riscv_pkg::*;

  logic            redirect;
  logic [XLEN-1:0] redirect_pc;
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic [ILEN-1:0] imem_rdata;
  logic            inst_valid;
  logic            inst_ready;
  logic [ILEN-1:0] inst;
  logic [XLEN-1:0] inst_pc;

  modport master (
    input  redirect, redirect_pc, imem_rdata, inst_ready,
    output imem_req, imem_addr, inst_valid, inst, inst_pc
  );

  modport slave (
    output redirect, redirect_pc, imem_rdata, inst_ready,
    input  imem_req, imem_addr, inst_valid, inst, inst_pc
  );

endinterface

// File: rtl/fetch_queue_sync_fifo.sv
// Single-clock FIFO with synchronous reset and flush; head is read combinationally.
module sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  input  logic                     flush,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  // Qualify requests against occupancy so a misuse can never corrupt state.
  always_comb begin
    push_ok_s = 1'b0;
    pop_ok_s  = 1'b0;
    if (count_r != CW'(DEPTH)) begin
      push_ok_s = push;
    end else begin
      push_ok_s = 1'b0;
    end
    if (count_r != CW'(0)) begin
      pop_ok_s = pop;
    end else begin
      pop_ok_s = 1'b0;
    end
  end

  // Storage write port.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

  // Pointers and occupancy; flush empties the queue without touching storage.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  assign dout  = mem_r[rd_ptr_r];
  assign full  = (count_r == CW'(DEPTH));
  assign empty = (count_r == CW'(0));
  assign count = count_r;

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch front end: one outstanding memory read feeding a small
// instruction queue, with redirect flush and synchronous reset.
module fetch_queue
  import riscv_pkg::*;
#(
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic          clk,
  input  logic          reset,
  fetch_queue_if.master bus
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [XLEN-1:0] fetch_pc_r;
  logic [XLEN-1:0] pending_pc_r;
  logic            inflight_r;
  logic            imem_req_s;
  logic            push_s;
  logic            pop_s;
  logic            valid_s;
  logic            full_s;
  logic            empty_s;
  logic [CW-1:0]   count_s;
  logic [CW-1:0]   occupancy_s;
  fetch_entry_t    push_entry_s;
  fetch_entry_t    head_entry_s;

  // Issue only when a slot is reserved for the response, counting the read in flight.
  always_comb begin
    occupancy_s = count_s + CW'(inflight_r);
    imem_req_s  = 1'b0;
    if (!reset && !bus.redirect && !full_s && (occupancy_s < CW'(DEPTH))) begin
      imem_req_s = 1'b1;
    end else begin
      imem_req_s = 1'b0;
    end
  end

  // Queue-side handshakes; a response landing during redirect or reset is dropped.
  always_comb begin
    valid_s      = !empty_s && !reset;
    pop_s        = valid_s && bus.inst_ready;
    push_s       = inflight_r && !bus.redirect && !reset;
    push_entry_s = '{inst: bus.imem_rdata, pc: pending_pc_r};
  end

  // Fetch address register.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_r <= RESET_PC;
    end else if (bus.redirect) begin
      fetch_pc_r <= align_pc(bus.redirect_pc);
    end else if (imem_req_s) begin
      fetch_pc_r <= fetch_pc_r + 32'd4;
    end
  end

  // Outstanding-read tracking.
  always_ff @(posedge clk) begin
    if (reset) begin
      inflight_r   <= 1'b0;
      pending_pc_r <= RESET_PC;
    end else begin
      inflight_r <= imem_req_s;
      if (imem_req_s) begin
        pending_pc_r <= fetch_pc_r;
      end
    end
  end

  sync_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_s),
    .din   (push_entry_s),
    .pop   (pop_s),
    .flush (bus.redirect),
    .dout  (head_entry_s),
    .full  (full_s),
    .empty (empty_s),
    .count (count_s)
  );

  assign bus.imem_req   = imem_req_s;
  assign bus.imem_addr  = reset ? RESET_PC : fetch_pc_r;
  assign bus.inst_valid = valid_s;
  assign bus.inst       = valid_s ? head_entry_s.inst : 32'h0000_0000;
  assign bus.inst_pc    = valid_s ? head_entry_s.pc   : 32'h0000_0000;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: reset, streaming, back-pressure, redirect,
// address wrap, mid-run reset and a randomised redirect/back-pressure run.
module tb_fetch_queue;
  import riscv_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   passes = 0;
  int   fails  = 0;

  always #5 clk = ~clk;

  fetch_queue_if bus ();
  fetch_queue_if bus2 ();

  fetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .reset(reset), .bus(bus.master)
  );

  fetch_queue #(.DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) dut2 (
    .clk(clk), .reset(reset), .bus(bus2.master)
  );

  // Memory models: data for address A is A + 0x100, one cycle after the request.
  always @(posedge clk) begin
    bus.imem_rdata  <= bus.imem_req  ? bus.imem_addr  + 32'h0000_0100 : 32'hDEAD_BEEF;
    bus2.imem_rdata <= bus2.imem_req ? bus2.imem_addr + 32'h0000_0100 : 32'hDEAD_BEEF;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic go(input logic r, input logic rdy, input logic rdr, input logic [31:0] rpc);
    @(posedge clk);
    #1;
    reset           = r;
    bus.inst_ready  = rdy;
    bus.redirect    = rdr;
    bus.redirect_pc = rpc;
    #2;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_req"},   32'(bus.imem_req),   32'd0);
    chk({tag, "_addr"},  bus.imem_addr,       32'h0000_0000);
    chk({tag, "_valid"}, 32'(bus.inst_valid), 32'd0);
    chk({tag, "_inst"},  bus.inst,            32'h0000_0000);
    chk({tag, "_pc"},    bus.inst_pc,         32'h0000_0000);
    chk({tag, "_addr2"}, bus2.imem_addr,      32'hFFFF_FFF8);
    chk({tag, "_valid2"}, 32'(bus2.inst_valid), 32'd0);
  endtask

  // Release from reset with decode always ready; also covers the wrapping instance.
  task automatic stream(input string tag);
    logic [31:0] pc2;
    for (int i = 0; i < 8; i++) begin
      go(1'b0, 1'b1, 1'b0, 32'h0);
      chk({tag, "_req"},  32'(bus.imem_req), 32'd1);
      chk({tag, "_addr"}, bus.imem_addr, 32'(4 * i));
      if (i < 2) begin
        chk({tag, "_novalid"}, 32'(bus.inst_valid), 32'd0);
      end else begin
        pc2 = 32'hFFFF_FFF8 + 32'(4 * (i - 2));
        chk({tag, "_valid"}, 32'(bus.inst_valid), 32'd1);
        chk({tag, "_pc"},    bus.inst_pc, 32'(4 * (i - 2)));
        chk({tag, "_inst"},  bus.inst, 32'(4 * (i - 2)) + 32'h0000_0100);
        chk({tag, "_wrap_pc"}, bus2.inst_pc, pc2);
      end
    end
  endtask

  // Reset, then fill with decode stalled for n cycles.
  task automatic fill(input int n);
    go(1'b1, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < n; i++) begin
      go(1'b0, 1'b0, 1'b0, 32'h0);
    end
  endtask

  initial begin
    logic [31:0] exp_pc;
    logic        rdy;
    logic        rdr;
    logic [31:0] rpc;
    int          pops;

    bus.inst_ready   = 1'b0;
    bus.redirect     = 1'b0;
    bus.redirect_pc  = 32'h0;
    bus2.inst_ready  = 1'b1;
    bus2.redirect    = 1'b0;
    bus2.redirect_pc = 32'h0;

    go(1'b1, 1'b1, 1'b0, 32'h0);
    go(1'b1, 1'b1, 1'b0, 32'h0);
    chk_reset("rst");
    stream("stream");

    // Back-pressure: four requests fill the queue, then fetch stalls.
    go(1'b1, 1'b0, 1'b0, 32'h0);
    chk_reset("rst_mid");
    for (int i = 0; i < 8; i++) begin
      go(1'b0, 1'b0, 1'b0, 32'h0);
      if (i < 4) begin
        chk("bp_req",  32'(bus.imem_req), 32'd1);
        chk("bp_addr", bus.imem_addr, 32'(4 * i));
      end else begin
        chk("bp_stall", 32'(bus.imem_req), 32'd0);
        chk("bp_hold_addr", bus.imem_addr, 32'h0000_0010);
      end
      if (i >= 2) begin
        chk("bp_head_pc",   bus.inst_pc, 32'h0000_0000);
        chk("bp_head_inst", bus.inst, 32'h0000_0100);
      end
    end
    for (int i = 0; i < 8; i++) begin
      go(1'b0, 1'b1, 1'b0, 32'h0);
      chk("bp_resume_valid", 32'(bus.inst_valid), 32'd1);
      chk("bp_resume_pc", bus.inst_pc, 32'(4 * i));
      if (i == 0) begin
        chk("bp_resume_req0", 32'(bus.imem_req), 32'd0);
      end else begin
        chk("bp_resume_req",  32'(bus.imem_req), 32'd1);
        chk("bp_resume_addr", bus.imem_addr, 32'h0000_0010 + 32'(4 * (i - 1)));
      end
    end

    // Redirect with three entries queued and the fourth read in flight.
    fill(4);
    go(1'b0, 1'b0, 1'b1, 32'h0000_2002);
    chk("rd_req_low", 32'(bus.imem_req), 32'd0);
    go(1'b0, 1'b1, 1'b0, 32'h0);
    chk("rd_flushed", 32'(bus.inst_valid), 32'd0);
    chk("rd_addr",    bus.imem_addr, 32'h0000_2000);
    chk("rd_req",     32'(bus.imem_req), 32'd1);
    go(1'b0, 1'b1, 1'b0, 32'h0);
    chk("rd_stale_hidden", 32'(bus.inst_valid), 32'd0);
    go(1'b0, 1'b1, 1'b0, 32'h0);
    chk("rd_first_pc",   bus.inst_pc, 32'h0000_2000);
    chk("rd_first_inst", bus.inst, 32'h0000_2100);
    go(1'b0, 1'b1, 1'b0, 32'h0);
    chk("rd_second_pc", bus.inst_pc, 32'h0000_2004);

    // Back-to-back redirects: the last target wins.
    go(1'b0, 1'b1, 1'b1, 32'h0000_3000);
    chk("b2b_req0", 32'(bus.imem_req), 32'd0);
    go(1'b0, 1'b1, 1'b1, 32'h0000_4001);
    chk("b2b_req1",  32'(bus.imem_req), 32'd0);
    chk("b2b_empty", 32'(bus.inst_valid), 32'd0);
    go(1'b0, 1'b1, 1'b0, 32'h0);
    chk("b2b_addr",  bus.imem_addr, 32'h0000_4000);
    chk("b2b_empty2", 32'(bus.inst_valid), 32'd0);
    go(1'b0, 1'b1, 1'b0, 32'h0);
    chk("b2b_empty3", 32'(bus.inst_valid), 32'd0);
    go(1'b0, 1'b1, 1'b0, 32'h0);
    chk("b2b_pc", bus.inst_pc, 32'h0000_4000);

    // One-cycle reset with the queue loaded and a read in flight, then replay.
    fill(4);
    go(1'b1, 1'b1, 1'b0, 32'h0);
    chk_reset("rst_busy");
    stream("replay");

    // Random back-pressure and redirects against a sequential PC model.
    go(1'b1, 1'b1, 1'b0, 32'h0);
    exp_pc = 32'h0000_0000;
    pops   = 0;
    for (int i = 0; i < 400; i++) begin
      rdy = ($urandom_range(0, 3) != 0);
      rdr = ($urandom_range(0, 19) == 0);
      rpc = $urandom;
      go(1'b0, rdy, rdr, rpc);
      if (bus.inst_valid && rdy) begin
        chk("rand_pc",   bus.inst_pc, exp_pc);
        chk("rand_inst", bus.inst, exp_pc + 32'h0000_0100);
        exp_pc = exp_pc + 32'd4;
        pops++;
      end
      if (rdr) begin
        chk("rand_redir_req", 32'(bus.imem_req), 32'd0);
        exp_pc = {rpc[31:2], 2'b00};
      end
      chk("rand_count_bound", 32'(dut.count_s > 3'd4), 32'd0);
    end
    chk("rand_progress", 32'(pops > 100), 32'd1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
